// File: rtl/testro_dac_pkg.sv
//-----------------------------------------------------------------------------
// testro_dac_pkg
//
// Shared definitions for the DAC serializer slice:
//   - serializer FSM state encoding (exposed on the debug port)
//   - frame length and counter widths
//   - legal ranges for the HALF_PERIOD and GAP_CYCLES parameters
//   - clamp helper used to keep parameters inside their legal range
//-----------------------------------------------------------------------------
`timescale 1ns/1ps

package testro_dac_pkg;

    // Number of data bits clocked out per frame, MSB first.
    localparam int FRAME_BITS = 32;

    // Phase counter (clk cycles per phase) and bit counter widths.
    localparam int PHASE_W   = 8;
    localparam int BIT_CNT_W = 6;

    // Legal parameter ranges.
    localparam int HALF_PERIOD_MIN = 2;
    localparam int HALF_PERIOD_MAX = 255;
    localparam int GAP_CYCLES_MIN  = 1;
    localparam int GAP_CYCLES_MAX  = 255;

    // Serializer FSM states. Encodings 5..7 are unused and recover to IDLE.
    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_SETUP    = 3'd1,
        ST_SHIFT_HI = 3'd2,
        ST_SHIFT_LO = 3'd3,
        ST_GAP      = 3'd4
    } state_t;

    // Force an elaboration-time parameter into [lo, hi] so an out-of-range
    // override can never wrap the 8-bit phase counter.
    function automatic int clamp_range(input int value, input int lo, input int hi);
        if (value < lo) begin
            return lo;
        end
        if (value > hi) begin
            return hi;
        end
        return value;
    endfunction

endpackage : testro_dac_pkg

// File: rtl/testro_dac_serializer_if.sv
//-----------------------------------------------------------------------------
// testro_dac_serializer_if
//
// Bundles the PIO-side control inputs and the DAC-side serial outputs of the
// serializer.
//
//   dac_word   : 32-bit DAC control word (quasi-static, same clock domain)
//   resend     : one-cycle pulse requesting a frame of the current word
//   dac_cs_n   : DAC chip select, active low
//   dac_sclk   : DAC serial clock
//   dac_din    : DAC serial data, MSB first
//   busy       : high from frame start until the FSM is back in IDLE
//   frame_done : one-cycle pulse in the cycle dac_cs_n returns high
//   dbg_state  : current serializer FSM state
//
// Handshake: there is no valid/ready pair. A frame is requested whenever
// dac_word differs from the last word sent, or resend pulses; requests
// arriving while busy are held and served once the FSM returns to IDLE.
//
// Modports:
//   master : the PIO side (drives dac_word/resend, observes everything else)
//   slave  : the serializer itself
//-----------------------------------------------------------------------------
`timescale 1ns/1ps

interface testro_dac_serializer_if;
    import testro_dac_pkg::*;

    logic [FRAME_BITS-1:0] dac_word;
    logic                  resend;
    logic                  dac_cs_n;
    logic                  dac_sclk;
    logic                  dac_din;
    logic                  busy;
    logic                  frame_done;
    state_t                dbg_state;

    modport master (
        output dac_word,
        output resend,
        input  dac_cs_n,
        input  dac_sclk,
        input  dac_din,
        input  busy,
        input  frame_done,
        input  dbg_state
    );

    modport slave (
        input  dac_word,
        input  resend,
        output dac_cs_n,
        output dac_sclk,
        output dac_din,
        output busy,
        output frame_done,
        output dbg_state
    );

endinterface : testro_dac_serializer_if

// File: rtl/testro_dac_phase_timer.sv
//-----------------------------------------------------------------------------
// testro_dac_phase_timer
//
// Reloadable 8-bit down-counter that times each serializer phase. Loading
// value N-1 makes the phase last N cycles: tick_o is high in the last cycle
// of the phase, which is the cycle in which the FSM moves on (and normally
// reloads the counter for the next phase in that same edge).
//
// Ports:
//   clk        : system clock, rising edge
//   reset_n    : asynchronous active-low reset
//   load_i     : reload the counter with load_val_i at the next edge
//   load_val_i : reload value (phase length minus one)
//   tick_o     : counter has reached zero (end of the current phase)
//-----------------------------------------------------------------------------
`timescale 1ns/1ps

module testro_dac_phase_timer
    import testro_dac_pkg::*;
(
    input  logic               clk,
    input  logic               reset_n,
    input  logic               load_i,
    input  logic [PHASE_W-1:0] load_val_i,
    output logic               tick_o
);

    logic [PHASE_W-1:0] count_q;
    logic [PHASE_W-1:0] count_d;

    // Saturates at zero, so an idle timer keeps reporting a tick and never
    // wraps back to 255.
    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = load_val_i;
        end else if (count_q != '0) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign tick_o = (count_q == '0);

endmodule : testro_dac_phase_timer

// File: rtl/testro_dac_serializer.sv
//-----------------------------------------------------------------------------
// testro_dac_serializer
//
// Sends the 32-bit DAC control word to a serial DAC as one chip-select framed
// SPI-like transfer (MSB first, data sampled by the DAC on rising dac_sclk).
// A frame is started whenever the word differs from the last word sent
// (held in a shadow register) or a resend has been requested.
//
// Frame timing, with H = HALF_PERIOD clk cycles:
//   SETUP     H cycles, cs_n=0, sclk=0, din=bit31
//   32 x ( SHIFT_HI H cycles sclk=1 ; SHIFT_LO H cycles sclk=0 )
//   -> cs_n low for exactly 65*H cycles, 32 rising sclk edges
//   GAP       GAP_CYCLES cycles with cs_n=1 (frame_done in the first one)
//   IDLE      at least one cycle before the next frame can start
//
// Parameters:
//   HALF_PERIOD : clk cycles per SCLK half period (2..255)
//   GAP_CYCLES  : minimum clk cycles of cs_n high between frames (1..255)
//
// Ports:
//   clk     : system clock, rising edge
//   reset_n : asynchronous active-low reset (aborts any frame at once)
//   bus     : slave side of testro_dac_serializer_if
//-----------------------------------------------------------------------------
`timescale 1ns/1ps

module testro_dac_serializer
    import testro_dac_pkg::*;
#(
    parameter int HALF_PERIOD = 4,
    parameter int GAP_CYCLES  = 8
)
(
    input  logic                     clk,
    input  logic                     reset_n,
    testro_dac_serializer_if.slave   bus
);

    localparam int HP_EFF  = clamp_range(HALF_PERIOD, HALF_PERIOD_MIN, HALF_PERIOD_MAX);
    localparam int GAP_EFF = clamp_range(GAP_CYCLES, GAP_CYCLES_MIN, GAP_CYCLES_MAX);

    localparam logic [PHASE_W-1:0]   HP_RELOAD  = PHASE_W'(HP_EFF - 1);
    localparam logic [PHASE_W-1:0]   GAP_RELOAD = PHASE_W'(GAP_EFF - 1);
    // Bit counter value during the 32nd high phase, and after it.
    localparam logic [BIT_CNT_W-1:0] LAST_BIT_IDX = BIT_CNT_W'(FRAME_BITS - 1);
    localparam logic [BIT_CNT_W-1:0] ALL_BITS     = BIT_CNT_W'(FRAME_BITS);

    state_t                state_q;
    logic [FRAME_BITS-1:0] shadow_q;
    logic [FRAME_BITS-1:0] shift_q;
    logic                  pending_q;
    logic [BIT_CNT_W-1:0]  bit_cnt_q;
    logic                  cs_n_q;
    logic                  sclk_q;
    logic                  busy_q;
    logic                  frame_done_q;

    logic                  start;
    logic                  phase_tick;
    logic                  timer_load;
    logic [PHASE_W-1:0]    timer_val;

    // A resend arriving in the same IDLE cycle starts the frame directly; it
    // does not need to pass through the pending flag first.
    assign start = (state_q == ST_IDLE) &&
                   ((bus.dac_word != shadow_q) || pending_q || bus.resend);

    // Timer reload: every phase transition reloads the counter for the phase
    // being entered. The last SHIFT_LO hands over to GAP.
    always_comb begin
        timer_load = 1'b0;
        timer_val  = HP_RELOAD;
        case (state_q)
            ST_IDLE: begin
                timer_load = start;
            end
            ST_SETUP, ST_SHIFT_HI: begin
                timer_load = phase_tick;
            end
            ST_SHIFT_LO: begin
                timer_load = phase_tick;
                if (bit_cnt_q == ALL_BITS) begin
                    timer_val = GAP_RELOAD;
                end
            end
            default: begin
                timer_load = 1'b0;
            end
        endcase
    end

    testro_dac_phase_timer u_phase_timer (
        .clk        (clk),
        .reset_n    (reset_n),
        .load_i     (timer_load),
        .load_val_i (timer_val),
        .tick_o     (phase_tick)
    );

    // Serializer FSM with registered outputs. dac_din is taken straight from
    // the MSB of the shift register, which is cleared outside a frame so the
    // line idles low.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            shadow_q     <= '0;
            shift_q      <= '0;
            pending_q    <= 1'b0;
            bit_cnt_q    <= '0;
            cs_n_q       <= 1'b1;
            sclk_q       <= 1'b0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            frame_done_q <= 1'b0;
            // Resends seen while a frame is in flight collapse into one flag;
            // the start edge below clears it again.
            if (bus.resend) begin
                pending_q <= 1'b1;
            end

            case (state_q)
                ST_IDLE: begin
                    cs_n_q <= 1'b1;
                    sclk_q <= 1'b0;
                    if (start) begin
                        state_q   <= ST_SETUP;
                        shift_q   <= bus.dac_word;
                        shadow_q  <= bus.dac_word;
                        pending_q <= 1'b0;
                        bit_cnt_q <= '0;
                        cs_n_q    <= 1'b0;
                        busy_q    <= 1'b1;
                    end
                end

                ST_SETUP: begin
                    if (phase_tick) begin
                        state_q <= ST_SHIFT_HI;
                        sclk_q  <= 1'b1;
                    end
                end

                ST_SHIFT_HI: begin
                    if (phase_tick) begin
                        state_q   <= ST_SHIFT_LO;
                        sclk_q    <= 1'b0;
                        bit_cnt_q <= bit_cnt_q + 1'b1;
                        // After the 32nd high phase bit0 stays on the line
                        // through the cs hold time.
                        if (bit_cnt_q != LAST_BIT_IDX) begin
                            shift_q <= {shift_q[FRAME_BITS-2:0], 1'b0};
                        end
                    end
                end

                ST_SHIFT_LO: begin
                    if (phase_tick) begin
                        if (bit_cnt_q == ALL_BITS) begin
                            state_q      <= ST_GAP;
                            cs_n_q       <= 1'b1;
                            frame_done_q <= 1'b1;
                            shift_q      <= '0;
                        end else begin
                            state_q <= ST_SHIFT_HI;
                            sclk_q  <= 1'b1;
                        end
                    end
                end

                ST_GAP: begin
                    if (phase_tick) begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end
                end

                default: begin
                    state_q   <= ST_IDLE;
                    shift_q   <= '0;
                    bit_cnt_q <= '0;
                    cs_n_q    <= 1'b1;
                    sclk_q    <= 1'b0;
                    busy_q    <= 1'b0;
                end
            endcase
        end
    end

    assign bus.dac_cs_n   = cs_n_q;
    assign bus.dac_sclk   = sclk_q;
    assign bus.dac_din    = shift_q[FRAME_BITS-1];
    assign bus.busy       = busy_q;
    assign bus.frame_done = frame_done_q;
    assign bus.dbg_state  = state_q;

endmodule : testro_dac_serializer

// File: tb/tb_testro_dac_serializer.sv
//-----------------------------------------------------------------------------
// tb_testro_dac_serializer
//
// Two serializers: dut_a at default parameters (H=4, gap 8) and dut_b at
// H=2, gap 1. A negedge monitor per DUT rebuilds each frame from the pins
// (word sampled on rising sclk, cs low length, sclk rises, frame_done at cs
// rise, cs high cycles before the frame). Expected words go into exp_q.
//-----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_testro_dac_serializer;
  import testro_dac_pkg::*;

  typedef struct {
    logic [31:0] word;
    int          low;
    int          rises;
    logic        fd;
    int          gap;
  } frame_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  testro_dac_serializer_if a_if();
  testro_dac_serializer_if b_if();

  testro_dac_serializer #(.HALF_PERIOD(4), .GAP_CYCLES(8)) u_dut_a (
    .clk(clk), .reset_n(reset_n), .bus(a_if.slave));
  testro_dac_serializer #(.HALF_PERIOD(2), .GAP_CYCLES(1)) u_dut_b (
    .clk(clk), .reset_n(reset_n), .bus(b_if.slave));

  int n_checks = 0;
  int n_fail = 0;
  logic [31:0] exp_q[$];
  frame_t a_frames[$];
  frame_t b_frames[$];

  // ---------------- monitors ----------------
  int a_low, a_rises, a_high, a_gap, a_fd_cnt = 0;
  logic [31:0] a_cap;
  logic a_prev_cs = 1'b1, a_prev_sclk = 1'b0;
  frame_t a_f;
  always @(negedge clk) begin
    if (!reset_n) begin
      a_low = 0; a_rises = 0; a_high = 0; a_prev_cs = 1'b1; a_prev_sclk = 1'b0;
    end else begin
      if (!a_if.dac_cs_n) begin
        if (a_prev_cs) begin a_low = 0; a_rises = 0; a_cap = '0; a_gap = a_high; end
        a_low++;
        if (a_if.dac_sclk && !a_prev_sclk) begin a_rises++; a_cap = {a_cap[30:0], a_if.dac_din}; end
      end else begin
        if (!a_prev_cs) begin
          a_f.word = a_cap; a_f.low = a_low; a_f.rises = a_rises; a_f.fd = a_if.frame_done; a_f.gap = a_gap;
          a_frames.push_back(a_f);
          a_high = 0;
        end
        a_high++;
      end
      if (a_if.frame_done) a_fd_cnt++;
      a_prev_cs = a_if.dac_cs_n; a_prev_sclk = a_if.dac_sclk;
    end
  end

  int b_low, b_rises, b_high, b_gap;
  logic [31:0] b_cap;
  logic b_prev_cs = 1'b1, b_prev_sclk = 1'b0;
  frame_t b_f;
  always @(negedge clk) begin
    if (!reset_n) begin
      b_low = 0; b_rises = 0; b_high = 0; b_prev_cs = 1'b1; b_prev_sclk = 1'b0;
    end else begin
      if (!b_if.dac_cs_n) begin
        if (b_prev_cs) begin b_low = 0; b_rises = 0; b_cap = '0; b_gap = b_high; end
        b_low++;
        if (b_if.dac_sclk && !b_prev_sclk) begin b_rises++; b_cap = {b_cap[30:0], b_if.dac_din}; end
      end else begin
        if (!b_prev_cs) begin
          b_f.word = b_cap; b_f.low = b_low; b_f.rises = b_rises; b_f.fd = b_if.frame_done; b_f.gap = b_gap;
          b_frames.push_back(b_f);
          b_high = 0;
        end
        b_high++;
      end
      b_prev_cs = b_if.dac_cs_n; b_prev_sclk = b_if.dac_sclk;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic pulse_resend_a();
    @(negedge clk); a_if.resend = 1'b1;
    @(negedge clk); a_if.resend = 1'b0;
  endtask

  // Waits until the chosen monitor holds n frames or the budget runs out.
  task automatic wait_frames(input bit sel_b, input int n, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if ((sel_b ? b_frames.size() : a_frames.size()) >= n) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    a_if.dac_word = '0; a_if.resend = 1'b0;
    b_if.dac_word = '0; b_if.resend = 1'b0;
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++; if (a_if.dac_cs_n !== 1'b1) begin n_fail++; $display("FAIL reset_cs_n: got %b want 1", a_if.dac_cs_n); end
    n_checks++; if (a_if.dac_sclk !== 1'b0) begin n_fail++; $display("FAIL reset_sclk: got %b want 0", a_if.dac_sclk); end
    n_checks++; if (a_if.dac_din !== 1'b0) begin n_fail++; $display("FAIL reset_din: got %b want 0", a_if.dac_din); end
    n_checks++; if (a_if.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", a_if.busy); end
    n_checks++; if (a_if.frame_done !== 1'b0) begin n_fail++; $display("FAIL reset_frame_done: got %b want 0", a_if.frame_done); end
    n_checks++; if (a_if.dbg_state !== ST_IDLE) begin n_fail++; $display("FAIL reset_state: got %0d want %0d", a_if.dbg_state, ST_IDLE); end
    reset_n = 1'b1;
    repeat (1000) @(negedge clk);
    n_checks++; if (a_frames.size() !== 0) begin n_fail++; $display("FAIL idle_no_frame_a: got %0d frames want 0", a_frames.size()); end
    n_checks++; if (b_frames.size() !== 0) begin n_fail++; $display("FAIL idle_no_frame_b: got %0d frames want 0", b_frames.size()); end
    n_checks++; if (a_fd_cnt !== 0) begin n_fail++; $display("FAIL idle_no_frame_done: got %0d want 0", a_fd_cnt); end
    n_checks++; if (a_if.dac_cs_n !== 1'b1) begin n_fail++; $display("FAIL idle_cs_n: got %b want 1", a_if.dac_cs_n); end
  endtask

  task automatic test_single_frame();
    bit ok; int fd0; frame_t f; logic [31:0] w;
    fd0 = a_fd_cnt;
    exp_q.push_back(32'hA5C3_0F81);
    @(negedge clk); a_if.dac_word = 32'hA5C3_0F81;
    @(negedge clk);
    n_checks++; if (a_if.dac_cs_n !== 1'b0) begin n_fail++; $display("FAIL start_cs_n: got %b want 0", a_if.dac_cs_n); end
    n_checks++; if (a_if.busy !== 1'b1) begin n_fail++; $display("FAIL start_busy: got %b want 1", a_if.busy); end
    n_checks++; if (a_if.dac_din !== 1'b1) begin n_fail++; $display("FAIL start_din_bit31: got %b want 1", a_if.dac_din); end
    n_checks++; if (a_if.dac_sclk !== 1'b0) begin n_fail++; $display("FAIL start_sclk: got %b want 0", a_if.dac_sclk); end
    n_checks++; if (a_if.dbg_state !== ST_SETUP) begin n_fail++; $display("FAIL start_state: got %0d want %0d", a_if.dbg_state, ST_SETUP); end
    wait_frames(1'b0, 1, 400, ok);
    n_checks++; if (ok !== 1'b1) begin n_fail++; $display("FAIL single_timeout: got %b want 1", ok); end
    n_checks++; if (a_frames.size() !== 1) begin n_fail++; $display("FAIL single_count: got %0d want 1", a_frames.size()); end
    while (a_frames.size() > 0) begin
      f = a_frames.pop_front();
      if (exp_q.size() > 0) w = exp_q.pop_front(); else w = 'x;
      n_checks++; if (f.word !== w) begin n_fail++; $display("FAIL single_word: got %h want %h", f.word, w); end
      n_checks++; if (f.low !== 260) begin n_fail++; $display("FAIL single_cs_low: got %0d want 260", f.low); end
      n_checks++; if (f.rises !== 32) begin n_fail++; $display("FAIL single_sclk_rises: got %0d want 32", f.rises); end
      n_checks++; if (f.fd !== 1'b1) begin n_fail++; $display("FAIL single_fd_at_cs_rise: got %b want 1", f.fd); end
    end
    exp_q.delete();
    repeat (12) @(negedge clk);
    n_checks++; if (a_if.busy !== 1'b0) begin n_fail++; $display("FAIL single_end_busy: got %b want 0", a_if.busy); end
    n_checks++; if (a_if.dbg_state !== ST_IDLE) begin n_fail++; $display("FAIL single_end_state: got %0d want %0d", a_if.dbg_state, ST_IDLE); end
    n_checks++; if (a_if.dac_din !== 1'b0) begin n_fail++; $display("FAIL single_end_din: got %b want 0", a_if.dac_din); end
    n_checks++; if (a_fd_cnt !== fd0 + 1) begin n_fail++; $display("FAIL single_fd_count: got %0d want %0d", a_fd_cnt, fd0 + 1); end
  endtask

  task automatic test_mid_frame_changes();
    bit ok; frame_t f; logic [31:0] w; int idx;
    exp_q.push_back(32'h1111_2222);
    exp_q.push_back(32'h0000_0003);
    @(negedge clk); a_if.dac_word = 32'h1111_2222;
    repeat (50) @(negedge clk); a_if.dac_word = 32'h0000_0001;
    repeat (50) @(negedge clk); a_if.dac_word = 32'h0000_0002;
    repeat (50) @(negedge clk); a_if.dac_word = 32'h0000_0003;
    wait_frames(1'b0, 2, 1200, ok);
    n_checks++; if (ok !== 1'b1) begin n_fail++; $display("FAIL midchg_timeout: got %b want 1", ok); end
    idx = 0;
    while (a_frames.size() > 0) begin
      f = a_frames.pop_front();
      if (exp_q.size() > 0) w = exp_q.pop_front(); else w = 'x;
      n_checks++; if (f.word !== w) begin n_fail++; $display("FAIL midchg_word%0d: got %h want %h", idx, f.word, w); end
      n_checks++; if (f.low !== 260) begin n_fail++; $display("FAIL midchg_cs_low%0d: got %0d want 260", idx, f.low); end
      if (idx > 0) begin
        n_checks++; if (f.gap !== 9) begin n_fail++; $display("FAIL midchg_gap%0d: got %0d want 9", idx, f.gap); end
      end
      idx++;
    end
    n_checks++; if (exp_q.size() !== 0) begin n_fail++; $display("FAIL midchg_missing: got %0d unsent want 0", exp_q.size()); end
    exp_q.delete();
    repeat (400) @(negedge clk);
    n_checks++; if (a_frames.size() !== 0) begin n_fail++; $display("FAIL midchg_extra: got %0d frames want 0", a_frames.size()); end
  endtask

  task automatic test_resend_merge();
    bit ok; frame_t f; logic [31:0] w; int fd0;
    fd0 = a_fd_cnt;
    exp_q.push_back(32'h0000_0003);
    exp_q.push_back(32'h0000_0003);
    pulse_resend_a();
    repeat (20) @(negedge clk); pulse_resend_a();
    repeat (40) @(negedge clk); pulse_resend_a();
    repeat (40) @(negedge clk); pulse_resend_a();
    wait_frames(1'b0, 2, 1500, ok);
    n_checks++; if (ok !== 1'b1) begin n_fail++; $display("FAIL resend_timeout: got %b want 1", ok); end
    while (a_frames.size() > 0) begin
      f = a_frames.pop_front();
      if (exp_q.size() > 0) w = exp_q.pop_front(); else w = 'x;
      n_checks++; if (f.word !== w) begin n_fail++; $display("FAIL resend_word: got %h want %h", f.word, w); end
      n_checks++; if (f.rises !== 32) begin n_fail++; $display("FAIL resend_rises: got %0d want 32", f.rises); end
    end
    exp_q.delete();
    repeat (400) @(negedge clk);
    n_checks++; if (a_frames.size() !== 0) begin n_fail++; $display("FAIL resend_extra: got %0d frames want 0", a_frames.size()); end
    n_checks++; if (a_fd_cnt !== fd0 + 2) begin n_fail++; $display("FAIL resend_fd_count: got %0d want %0d", a_fd_cnt, fd0 + 2); end
  endtask

  task automatic test_change_and_resend();
    bit ok; frame_t f; logic [31:0] w;
    exp_q.push_back(32'h0F0F_0F0F);
    @(negedge clk); a_if.dac_word = 32'h0F0F_0F0F; a_if.resend = 1'b1;
    @(negedge clk); a_if.resend = 1'b0;
    wait_frames(1'b0, 1, 400, ok);
    n_checks++; if (ok !== 1'b1) begin n_fail++; $display("FAIL chgres_timeout: got %b want 1", ok); end
    while (a_frames.size() > 0) begin
      f = a_frames.pop_front();
      if (exp_q.size() > 0) w = exp_q.pop_front(); else w = 'x;
      n_checks++; if (f.word !== w) begin n_fail++; $display("FAIL chgres_word: got %h want %h", f.word, w); end
    end
    exp_q.delete();
    repeat (400) @(negedge clk);
    n_checks++; if (a_frames.size() !== 0) begin n_fail++; $display("FAIL chgres_extra: got %0d frames want 0", a_frames.size()); end
  endtask

  task automatic test_reset_mid_frame();
    bit ok; frame_t f; logic [31:0] w; int fd0;
    exp_q.push_back(32'hDEAD_BEEF);
    @(negedge clk); a_if.dac_word = 32'hDEAD_BEEF;
    repeat (100) @(negedge clk);
    n_checks++; if (a_if.dac_cs_n !== 1'b0) begin n_fail++; $display("FAIL rstmid_in_frame: got %b want 0", a_if.dac_cs_n); end
    fd0 = a_fd_cnt;
    #2 reset_n = 1'b0;
    #1;
    n_checks++; if (a_if.dac_cs_n !== 1'b1) begin n_fail++; $display("FAIL rstmid_cs_n: got %b want 1", a_if.dac_cs_n); end
    n_checks++; if (a_if.dac_sclk !== 1'b0) begin n_fail++; $display("FAIL rstmid_sclk: got %b want 0", a_if.dac_sclk); end
    n_checks++; if (a_if.busy !== 1'b0) begin n_fail++; $display("FAIL rstmid_busy: got %b want 0", a_if.busy); end
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    n_checks++; if (a_frames.size() !== 0) begin n_fail++; $display("FAIL rstmid_aborted_logged: got %0d want 0", a_frames.size()); end
    wait_frames(1'b0, 1, 400, ok);
    n_checks++; if (ok !== 1'b1) begin n_fail++; $display("FAIL rstmid_timeout: got %b want 1", ok); end
    while (a_frames.size() > 0) begin
      f = a_frames.pop_front();
      if (exp_q.size() > 0) w = exp_q.pop_front(); else w = 'x;
      n_checks++; if (f.word !== w) begin n_fail++; $display("FAIL rstmid_word: got %h want %h", f.word, w); end
      n_checks++; if (f.low !== 260) begin n_fail++; $display("FAIL rstmid_cs_low: got %0d want 260", f.low); end
      n_checks++; if (f.rises !== 32) begin n_fail++; $display("FAIL rstmid_rises: got %0d want 32", f.rises); end
    end
    exp_q.delete();
    n_checks++; if (a_fd_cnt !== fd0 + 1) begin n_fail++; $display("FAIL rstmid_fd_count: got %0d want %0d", a_fd_cnt, fd0 + 1); end
  endtask

  task automatic test_back_to_back();
    bit ok; frame_t f; logic [31:0] w; int idx;
    exp_q.push_back(32'h1234_5678);
    exp_q.push_back(32'h9ABC_DEF0);
    exp_q.push_back(32'h0000_FFFF);
    @(negedge clk); b_if.dac_word = 32'h1234_5678;
    repeat (10) @(negedge clk); b_if.dac_word = 32'h9ABC_DEF0;
    repeat (140) @(negedge clk); b_if.dac_word = 32'h0000_FFFF;
    wait_frames(1'b1, 3, 800, ok);
    n_checks++; if (ok !== 1'b1) begin n_fail++; $display("FAIL b2b_timeout: got %b want 1", ok); end
    idx = 0;
    while (b_frames.size() > 0) begin
      f = b_frames.pop_front();
      if (exp_q.size() > 0) w = exp_q.pop_front(); else w = 'x;
      n_checks++; if (f.word !== w) begin n_fail++; $display("FAIL b2b_word%0d: got %h want %h", idx, f.word, w); end
      n_checks++; if (f.low !== 130) begin n_fail++; $display("FAIL b2b_cs_low%0d: got %0d want 130", idx, f.low); end
      n_checks++; if (f.rises !== 32) begin n_fail++; $display("FAIL b2b_rises%0d: got %0d want 32", idx, f.rises); end
      if (idx > 0) begin
        n_checks++; if (f.gap !== 2) begin n_fail++; $display("FAIL b2b_gap%0d: got %0d want 2", idx, f.gap); end
      end
      idx++;
    end
    n_checks++; if (idx !== 3) begin n_fail++; $display("FAIL b2b_count: got %0d want 3", idx); end
    exp_q.delete();
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_single_frame();
    test_mid_frame_changes();
    test_resend_merge();
    test_change_and_resend();
    test_reset_mid_frame();
    test_back_to_back();
    repeat (5) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got no finish want finish");
    $fatal(1, "watchdog");
  end

endmodule : tb_testro_dac_serializer

// File: doc/testro_dac_serializer.md
TESTRO_DAC_SERIALIZER -- requirements
Module: testro_dac_serializer

Interface
REQ-001 Parameter HALF_PERIOD, default 4: clk cycles per SCLK half-period; legal range 2..255.
REQ-002 Parameter GAP_CYCLES, default 8: minimum clk cycles cs_n stays high between frames; legal range 1..255.
REQ-003 Port clk  input  1  single system clock; all logic on its rising edge.
REQ-004 Port reset_n  input  1  asynchronous, active-low reset.
REQ-005 Port dac_word  input  32  DAC control word from the dacctrl PIO out_port; quasi-static, same clock domain.
REQ-006 Port resend  input  1  one-cycle pulse; forces a frame of the current dac_word even if unchanged.
REQ-007 Port dac_cs_n  output  1  DAC chip select, active low.
REQ-008 Port dac_sclk  output  1  DAC serial clock.
REQ-009 Port dac_din  output  1  DAC serial data, MSB first.
REQ-010 Port busy  output  1  high from the frame-start cycle until the return to IDLE.
REQ-011 Port frame_done  output  1  one-cycle pulse in the cycle dac_cs_n returns high.

Function
REQ-012 The serializer SHALL hold a 32-bit shadow register of the last word sent; a frame SHALL start when the FSM is in IDLE and (dac_word != shadow or a resend is pending).
REQ-013 FSM states SHALL be IDLE, SETUP, SHIFT_HI, SHIFT_LO, GAP; any other encoding SHALL recover to IDLE.
REQ-014 IDLE -> SETUP on a start condition: at that edge the serializer SHALL load dac_word into the shift register and the shadow, drive dac_cs_n=0 and dac_din=bit31, assert busy, and clear any pending resend.
REQ-015 SETUP SHALL last HALF_PERIOD cycles with dac_sclk=0, then enter SHIFT_HI.
REQ-016 SHIFT_HI SHALL last HALF_PERIOD cycles with dac_sclk=1; the DAC samples dac_din on the rising dac_sclk edge.
REQ-017 SHIFT_LO SHALL last HALF_PERIOD cycles with dac_sclk=0; on entry the serializer SHALL present the next lower bit on dac_din, except after the 32nd high phase, when dac_din holds bit0.
REQ-018 After 32 SHIFT_HI phases, the final SHIFT_LO SHALL act as the cs hold time, then enter GAP with dac_cs_n=1 and frame_done=1 for that one cycle.
REQ-019 dac_cs_n low duration SHALL be exactly 65*HALF_PERIOD cycles (260 at the default); exactly 32 rising dac_sclk edges per frame.
REQ-020 GAP SHALL last GAP_CYCLES cycles, then enter IDLE with busy=0; a pending start SHALL then be honoured on the next edge.
REQ-021 dac_word changes while busy SHALL NOT alter the frame in flight; only the value present on return to IDLE is sent, and intermediate values are dropped.
REQ-022 A resend pulse while busy SHALL be latched as pending and SHALL produce exactly one extra frame; multiple pulses in one frame SHALL merge into one.
REQ-023 Simultaneous change and resend in IDLE SHALL produce exactly one frame.
REQ-024 In IDLE, dac_sclk=0, dac_cs_n=1, dac_din=0.
REQ-025 The phase counter SHALL be 8 bits and the bit counter 6 bits, with no wrap inside a frame.

Reset
REQ-026 When reset_n is low: state=IDLE; shadow=0; shift register=0; pending=0; counters=0; dac_cs_n=1; dac_sclk=0; dac_din=0; busy=0; frame_done=0.
REQ-027 Reset asserted mid-frame SHALL abort immediately with dac_cs_n=1, and no frame_done is issued.
REQ-028 Because shadow and PIO reset value are both 0, no frame SHALL be emitted after reset until dac_word changes or resend pulses.

Structure
REQ-029 The FSM state enumeration, FRAME_BITS=32, and the legal ranges of HALF_PERIOD and GAP_CYCLES SHALL live in a shared testro_dac_pkg package.
REQ-030 One sub-module, testro_dac_phase_timer, SHALL implement the reloadable down-counter generating the end-of-phase tick; all other logic is flat.

Verification
REQ-031 Reset, then dac_word=0 for 1000 cycles -> dac_cs_n stays 1 and no frame_done.
REQ-032 dac_word=0xA5C3_0F81 at default parameters -> dac_cs_n low 260 cycles, 32 SCLK rises, bits sampled on the rising edges read 0xA5C30F81, then one frame_done.
REQ-033 Word 0x1 mid-frame, then 0x2 mid-frame, then 0x3 mid-frame -> the current frame is unchanged, and exactly one following frame carries 0x00000003 after at least 8 high cycles of dac_cs_n.
REQ-034 Three resend pulses during a frame with unchanged dac_word -> exactly one extra identical frame.
REQ-035 reset_n asserted 100 cycles into a frame -> dac_cs_n=1 and dac_sclk=0 asynchronously; after release with dac_word unchanged and nonzero, a fresh full frame is sent.
REQ-036 HALF_PERIOD=2, GAP_CYCLES=1, back-to-back changes -> dac_cs_n low 130 cycles per frame, with at least 1 high cycle between frames.
